// File: rtl/count_event_logger.sv
// Passive monitor for a modulo counter: classifies wrap/illegal/skip transitions and
// streams timestamped records out through a small valid/ready FIFO.
module count_event_logger #(
    parameter int unsigned MODULUS  = 6,
    parameter int unsigned TS_WIDTH = 16,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TS_WIDTH+1:0] out_data,
    output logic                overflow,
    output logic [7:0]          drops
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [3:0] LAST_VALUE = 4'(MODULUS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        KindNone    = 2'b00,
        KindWrap    = 2'b01,
        KindIllegal = 2'b10,
        KindSkip    = 2'b11
    } kind_e;

    logic [TS_WIDTH-1:0] r_ts;
    logic [3:0]          r_prev;
    logic                r_primed;
    logic [TS_WIDTH+1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [OCC_W-1:0]    r_occ;
    logic                r_overflow;
    logic [7:0]          r_drops;

    kind_e               w_kind;
    logic [3:0]          w_prev_inc;
    logic                w_event;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [OCC_W-1:0]    w_occ_next;

    assign w_prev_inc = r_prev + 4'd1;

    // Priority: illegal value beats wrap beats skip; hold and +1 are quiet.
    always_comb begin
        w_kind = KindNone;
        if (r_primed) begin
            if (32'(count) >= MODULUS) begin
                w_kind = KindIllegal;
            end else if (r_prev == LAST_VALUE && count == 4'd0) begin
                w_kind = KindWrap;
            end else if (count != r_prev && count != w_prev_inc) begin
                w_kind = KindSkip;
            end
        end
    end

    assign w_event = (w_kind != KindNone);
    assign w_pop   = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = w_event && ((r_occ != OCC_FULL) || w_pop);
    assign w_drop  = w_event && !w_push;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + OCC_W'(1);
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts       <= '0;
            r_prev     <= count;
            r_primed   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
            r_drops    <= 8'd0;
        end else begin
            r_ts     <= r_ts + TS_WIDTH'(1);
            r_prev   <= count;
            r_primed <= 1'b1;
            r_occ    <= w_occ_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drops != 8'hFF) begin
                    r_drops <= r_drops + 8'd1;
                end
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_kind, r_ts};
        end
    end

    assign out_valid = (r_occ != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;
    assign drops     = r_drops;

endmodule
